// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: latches the fetched word into IR and walks
// each instruction through a Moore FSM that drives PC, RF, ALU, EXT and DM controls.
module mc_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic [31:0] IR,
    output logic        PCWr,
    output logic [1:0]  NPCOp,
    output logic        IRWr,
    output logic        RFWr,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic        ALUSrc,
    output logic [1:0]  ExtOp,
    output logic [1:0]  ALUOp,
    output logic        DMWr,
    output logic        Done,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE_R  = 4'd2,
        WB_R   = 4'd3,
        EXE_I  = 4'd4,
        WB_I   = 4'd5,
        MEMADR = 4'd6,
        MEMRD  = 4'd7,
        MEMWB  = 4'd8,
        MEMWR  = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

    state_t state;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic isAddu, isSubu, isJr, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;

    // Decoding always looks at the latched IR so it stays stable across the instruction.
    assign opcode = IR[31:26];
    assign funct  = IR[5:0];
    assign isAddu = (opcode == 6'b000000) && (funct == 6'b100001);
    assign isSubu = (opcode == 6'b000000) && (funct == 6'b100011);
    assign isJr   = (opcode == 6'b000000) && (funct == 6'b001000);
    assign isOri  = (opcode == 6'b001101);
    assign isLui  = (opcode == 6'b001111);
    assign isLw   = (opcode == 6'b100011);
    assign isSw   = (opcode == 6'b101011);
    assign isBeq  = (opcode == 6'b000100);
    assign isJ    = (opcode == 6'b000010);
    assign isJal  = (opcode == 6'b000011);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FETCH;
            IR    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    IR    <= Instr;
                    state <= DECODE;
                end
                DECODE: begin
                    if (isAddu || isSubu)
                        state <= EXE_R;
                    else if (isOri || isLui)
                        state <= EXE_I;
                    else if (isLw || isSw)
                        state <= MEMADR;
                    else if (isBeq)
                        state <= BRANCH;
                    else if (isJ)
                        state <= JUMP;
                    else if (isJal)
                        state <= JAL;
                    else if (isJr)
                        state <= JR;
                    else
                        state <= FETCH;
                end
                EXE_R:  state <= WB_R;
                EXE_I:  state <= WB_I;
                MEMADR: state <= isLw ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                // Final states, and any corrupted encoding, return to FETCH.
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCWr    = 1'b0;
        NPCOp   = 2'b00;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 2'b00;
        ALUSrc  = 1'b0;
        ExtOp   = 2'b00;
        ALUOp   = 2'b00;
        DMWr    = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        case (state)
            FETCH: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            DECODE: begin
                Illegal = !(isAddu || isSubu || isJr || isOri || isLui ||
                            isLw || isSw || isBeq || isJ || isJal);
            end
            EXE_R: begin
                ALUOp = isSubu ? 2'b01 : 2'b00;
            end
            WB_R: begin
                ALUOp  = isSubu ? 2'b01 : 2'b00;
                RFWr   = 1'b1;
                RegDst = 2'b01;
                Done   = 1'b1;
            end
            EXE_I: begin
                ALUSrc = 1'b1;
                ALUOp  = 2'b10;
                ExtOp  = isLui ? 2'b10 : 2'b00;
            end
            WB_I: begin
                ALUSrc = 1'b1;
                ALUOp  = 2'b10;
                ExtOp  = isLui ? 2'b10 : 2'b00;
                RFWr   = 1'b1;
                Done   = 1'b1;
            end
            MEMADR, MEMRD: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
            end
            MEMWB: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
                RFWr   = 1'b1;
                WDSel  = 2'b01;
                Done   = 1'b1;
            end
            MEMWR: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
                DMWr   = 1'b1;
                Done   = 1'b1;
            end
            BRANCH: begin
                ALUOp = 2'b01;
                NPCOp = 2'b01;
                PCWr  = Zero;
                Done  = 1'b1;
            end
            JUMP: begin
                PCWr  = 1'b1;
                NPCOp = 2'b10;
                Done  = 1'b1;
            end
            // Link value is the PC already advanced in FETCH, written alongside the jump.
            JAL: begin
                PCWr   = 1'b1;
                NPCOp  = 2'b10;
                RFWr   = 1'b1;
                RegDst = 2'b10;
                WDSel  = 2'b10;
                Done   = 1'b1;
            end
            JR: begin
                PCWr  = 1'b1;
                NPCOp = 2'b11;
                Done  = 1'b1;
            end
            default: begin
                PCWr = 1'b0;
            end
        endcase
        // Reset suppresses every architectural write in the same cycle.
        if (Rst) begin
            PCWr = 1'b0;
            IRWr = 1'b0;
            RFWr = 1'b0;
            DMWr = 1'b0;
        end
    end

endmodule
